alu_exec_unit: RTL and testbench

- Sequential execute unit on the consumer side of the 3-bit ALUControl code produced by the control path's ALU decoder.
- Accepts operands and an ALUControl code over a valid/ready handshake and returns a registered result plus a Zero flag.
- Add, sub, AND, OR, SLT and XOR take one cycle.
- The two spare codes implement logical shifts iteratively, one bit per cycle, so no barrel shifter is needed.

---
 rtl/alu_exec_unit.sv | 207 ++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: sequential execute unit behind the ALU decoder.
// Single-cycle ADD/SUB/AND/OR/SLT/XOR; SLL/SRL are iterated one bit per cycle.
// Optional build macro ALU_FLAGS_EN adds registered Negative/Carry/Overflow outputs.
//
// state  | meaning
// IDLE   | waiting for an operation
// SHIFT  | iterative shift in progress
// DONE   | result held on the outputs until out_ready
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
`ifdef ALU_FLAGS_EN
  ,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
`endif
);

  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;

  logic [WIDTH-1:0]   sum_w;
  logic [WIDTH-1:0]   diff_w;
  logic               sub_ovf;
  logic               slt_lt;
  logic [WIDTH-1:0]   op_res;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic [WIDTH-1:0]   shift_step;
  logic               accept;

`ifdef ALU_FLAGS_EN
  logic neg_q, neg_d;
  logic carry_q, carry_d;
  logic ovf_q, ovf_d;
  logic add_ovf;
  logic add_carry;
  logic sub_carry;
  logic op_carry;
  logic op_ovf;
`endif

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign ALUResult = result_q;
  assign Zero      = zero_q;
`ifdef ALU_FLAGS_EN
  assign Negative  = neg_q;
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;
`endif

  // Datapath for single-cycle ops; SLT corrects the diff sign with signed overflow.
  always_comb begin
    sum_w    = SrcA + SrcB;
    diff_w   = SrcA - SrcB;
    sub_ovf  = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff_w[WIDTH-1] != SrcA[WIDTH-1]);
    slt_lt   = diff_w[WIDTH-1] ^ sub_ovf;
    shamt    = SrcB[SHAMT_W-1:0];
    is_shift = (ALUControl == 3'b100) || (ALUControl == 3'b111);
    op_res   = '0;
    case (ALUControl)
      3'b000:  op_res = sum_w;
      3'b001:  op_res = diff_w;
      3'b010:  op_res = SrcA & SrcB;
      3'b011:  op_res = SrcA | SrcB;
      3'b101:  op_res = {{(WIDTH-1){1'b0}}, slt_lt};
      3'b110:  op_res = SrcA ^ SrcB;
      default: op_res = SrcA;  // shift by zero passes A through
    endcase
  end

`ifdef ALU_FLAGS_EN
  // Flag generation: carry is NOT-borrow for SUB/SLT, zero for logic and shifts.
  always_comb begin
    add_ovf   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum_w[WIDTH-1] != SrcA[WIDTH-1]);
    add_carry = (sum_w < SrcA);
    sub_carry = (SrcA >= SrcB);
    op_carry  = 1'b0;
    op_ovf    = 1'b0;
    case (ALUControl)
      3'b000: begin
        op_carry = add_carry;
        op_ovf   = add_ovf;
      end
      3'b001, 3'b101: begin
        op_carry = sub_carry;
        op_ovf   = sub_ovf;
      end
      default: begin
        op_carry = 1'b0;
        op_ovf   = 1'b0;
      end
    endcase
  end
`endif

  assign shift_step = dir_q ? (work_q >> 1) : (work_q << 1);

  // Next-state and register-load logic for the three-state controller.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
`ifdef ALU_FLAGS_EN
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_SHIFT: begin
        work_d = shift_step;
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d  = S_DONE;
          result_d = shift_step;
          zero_d   = (shift_step == '0);
`ifdef ALU_FLAGS_EN
          neg_d    = shift_step[WIDTH-1];
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
`endif
        end
      end
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            state_d = S_SHIFT;
            work_d  = SrcA;
            cnt_d   = shamt;
            dir_d   = ALUControl[0];  // 100 = left, 111 = right
          end else begin
            state_d  = S_DONE;
            result_d = op_res;
            zero_d   = (op_res == '0);
`ifdef ALU_FLAGS_EN
            neg_d    = op_res[WIDTH-1];
            carry_d  = op_carry;
            ovf_d    = op_ovf;
`endif
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      work_q   <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
`ifdef ALU_FLAGS_EN
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
`ifdef ALU_FLAGS_EN
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: transaction-level model plus directed vectors.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] SrcA, SrcB;
  logic [2:0]  ALUControl;
  logic        in_ready, out_valid, Zero;
  logic [31:0] ALUResult;
`ifdef ALU_FLAGS_EN
  logic        Negative, Carry, Overflow;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .SrcA(SrcA),
    .SrcB(SrcB),
    .ALUControl(ALUControl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALUResult(ALUResult),
    .Zero(Zero)
`ifdef ALU_FLAGS_EN
    ,
    .Negative(Negative),
    .Carry(Carry),
    .Overflow(Overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic from the operation definitions.
  function automatic logic [31:0] ref_res(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a << b[4:0];
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b110:  return a ^ b;
      default: return a >> b[4:0];
    endcase
  endfunction

  function automatic void ref_flags(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                    output logic cy, output logic ov);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cy = 1'b0;
    ov = 1'b0;
    if (c == 3'b000) begin
      s  = sa + sb;
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      cy = (longint'(a) + longint'(b)) >= 64'h1_0000_0000;
    end else if (c == 3'b001 || c == 3'b101) begin
      s  = sa - sb;
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      cy = (a >= b);
    end
  endfunction

  // Transaction model: busy counter for shifts, one result slot held until consumed.
  logic        m_valid = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pending = '0;
  int          m_busy = 0;
  logic        m_cy = 1'b0, m_ov = 1'b0;

  function automatic logic model_ready();
    return (m_busy == 0) && (!m_valid || out_ready);
  endfunction

  always @(posedge clk) begin
    logic acc;
    logic cy, ov;
    acc = in_valid && model_ready();
    if (reset) begin
      m_valid  = 1'b0;
      m_result = '0;
      m_busy   = 0;
      m_cy     = 1'b0;
      m_ov     = 1'b0;
    end else begin
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid  = 1'b1;
          m_result = m_pending;
          m_cy     = 1'b0;
          m_ov     = 1'b0;
        end
      end else if (m_valid && out_ready && !acc) begin
        m_valid = 1'b0;
      end
      if (acc) begin
        ref_flags(ALUControl, SrcA, SrcB, cy, ov);
        if ((ALUControl == 3'b100 || ALUControl == 3'b111) && SrcB[4:0] != 5'd0) begin
          m_busy    = int'(SrcB[4:0]);
          m_valid   = 1'b0;
          m_pending = ref_res(ALUControl, SrcA, SrcB);
        end else begin
          m_valid  = 1'b1;
          m_result = ref_res(ALUControl, SrcA, SrcB);
          m_cy     = cy;
          m_ov     = ov;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(model_ready()));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("ALUResult", ALUResult, m_result);
      if (m_valid) begin
        chk("Zero", 32'(Zero), 32'(m_result == 32'd0));
`ifdef ALU_FLAGS_EN
        chk("Negative", 32'(Negative), 32'(m_result[31]));
        chk("Carry", 32'(Carry), 32'(m_cy));
        chk("Overflow", 32'(Overflow), 32'(m_ov));
`endif
      end
    end
  end

  task automatic do_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input logic ordy,
                       input string nm, output int aw);
    bit got;
    @(posedge clk);
    #1;
    in_valid   = 1'b1;
    ALUControl = c;
    SrcA       = a;
    SrcB       = b;
    out_ready  = ordy;
    got = 1'b0;
    aw  = 0;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        got = 1'b1;
        aw  = k;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s accept: got timeout expected in_ready", nm);
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    ALUControl = 3'b010;
    SrcA       = 32'hDEAD_BEEF;
    SrcB       = 32'h0000_0003;
    got = 1'b0;
    for (int k = 1; k <= 100 && !got; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        got = 1'b1;
        chk({nm, " latency"}, 32'(k), 32'(lat));
        chk({nm, " result"}, ALUResult, exp);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s out_valid: got timeout expected pulse", nm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int aw;
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    SrcA       = '0;
    SrcB       = '0;
    ALUControl = '0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", ALUResult, 32'd0);
    chk("reset zero", 32'(Zero), 32'd0);

    do_op(3'b000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1, 1'b1, "add", aw);
    chk("add zero", 32'(Zero), 32'd0);
    @(negedge clk);
    chk("add pulse end", 32'(out_valid), 32'd0);

    do_op(3'b001, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1, 1'b1, "sub eq", aw);
    chk("sub zero", 32'(Zero), 32'd1);
    do_op(3'b001, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1, 1'b1, "sub wrap", aw);
    do_op(3'b101, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1, 1'b1, "slt min", aw);
    do_op(3'b101, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b1, "slt max", aw);

    do_op(3'b100, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32, 1'b1, "sll 31", aw);
    do_op(3'b111, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 5, 1'b1, "srl 4", aw);
    do_op(3'b100, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1, 1'b1, "sll 0", aw);

    do_op(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, 1'b0, "and bp", aw);
    repeat (5) begin
      @(negedge clk);
      chk("bp hold result", ALUResult, 32'hF000_F000);
      chk("bp hold valid", 32'(out_valid), 32'd1);
      chk("bp in_ready", 32'(in_ready), 32'd0);
    end
    do_op(3'b110, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678, 1, 1'b1, "xor b2b", aw);
    chk("xor same-cycle accept", 32'(aw), 32'd1);

    @(posedge clk);
    #1;
    in_valid   = 1'b1;
    ALUControl = 3'b111;
    SrcA       = 32'hFFFF_FFFF;
    SrcB       = 32'h0000_0014;
    @(negedge clk);
    chk("srl20 accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort result", ALUResult, 32'd0);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    do_op(3'b011, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1, 1'b1, "or after abort", aw);

`ifdef ALU_FLAGS_EN
    do_op(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, 1'b1, "add ovf", aw);
    chk("add ovf Overflow", 32'(Overflow), 32'd1);
    chk("add ovf Negative", 32'(Negative), 32'd1);
    chk("add ovf Carry", 32'(Carry), 32'd0);
    do_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1'b1, "add carry", aw);
    chk("add carry Zero", 32'(Zero), 32'd1);
    chk("add carry Carry", 32'(Carry), 32'd1);
    chk("add carry Overflow", 32'(Overflow), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
